// File: rtl/seg_clock_pkg.sv
// Shared constants for the segment clock: BCD field widths, 7-segment glyphs
// ({g,f,e,d,c,b,a}, active-high) and the 24h -> 12h hour helper.
package seg_clock_pkg;

  localparam int ONES_W  = 4;  // any ones digit 0..9
  localparam int MIN_T_W = 3;  // minute tens 0..5
  localparam int HR_T_W  = 2;  // hour tens 0..2

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Binary hour 0..23 to the 12h face value 1..12 (midnight shows as 12)
  function automatic logic [4:0] hour_to_12h(input logic [4:0] hr_24);
    if (hr_24 == 5'd0) begin
      hour_to_12h = 5'd12;
    end else if (hr_24 > 5'd12) begin
      hour_to_12h = hr_24 - 5'd12;
    end else begin
      hour_to_12h = hr_24;
    end
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit plus blank flag to a 7-segment pattern.
module seg7_decode
  import seg_clock_pkg::*;
(
  input  logic [ONES_W-1:0] digit,
  input  logic              blank,
  output logic [6:0]        seg
);

  // Glyph lookup; blank or a non-decimal code shows nothing
  always_comb begin
    seg = GLYPH_BLANK;
    if (blank) begin
      seg = GLYPH_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = GLYPH_0;
        4'd1:    seg = GLYPH_1;
        4'd2:    seg = GLYPH_2;
        4'd3:    seg = GLYPH_3;
        4'd4:    seg = GLYPH_4;
        4'd5:    seg = GLYPH_5;
        4'd6:    seg = GLYPH_6;
        4'd7:    seg = GLYPH_7;
        4'd8:    seg = GLYPH_8;
        4'd9:    seg = GLYPH_9;
        default: seg = GLYPH_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_clock_mux.sv
// Multiplexed 7-segment clock: 2 Hz timebase, BCD HH:MM[:SS], digit scan,
// set buttons and a safe (display off) mode.
// Optional macro SEG_CLOCK_DEBOUNCE_EN adds a 2-flop synchroniser and a
// 2^MUX_LOG2-cycle debounce filter on btn_hh/btn_mm/btn_ss.
module seg_clock_mux
  import seg_clock_pkg::*;
#(
  parameter int CLK_HZ     = 32768,
  parameter int SHOW_SEC   = 0,
  parameter int MUX_LOG2   = 7,
  parameter int MODE_12H   = 0,
  parameter int FLASH_LOG2 = 6,
  localparam int NDIG      = 4 + 2 * SHOW_SEC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_hh,
  input  logic            btn_mm,
  input  logic            btn_ss,
  input  logic            btn_safe_n,
  output logic [6:0]      seg,
  output logic [NDIG-1:0] dig_en,
  output logic            sec_led,
  output logic            pm
);

  localparam int PW = $clog2(CLK_HZ / 2);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ / 2 - 1);

  logic btn_hh_s, btn_mm_s, btn_ss_s;

`ifdef SEG_CLOCK_DEBOUNCE_EN
  logic [2:0]          sync1_r, sync2_r, filt_r;
  logic [MUX_LOG2-1:0] db_cnt_r [3];

  // Synchronise each button, then accept a new level only after it held 2^MUX_LOG2 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      filt_r  <= 3'b000;
      for (int i = 0; i < 3; i++) db_cnt_r[i] <= {MUX_LOG2{1'b0}};
    end else begin
      sync1_r <= {btn_ss, btn_mm, btn_hh};
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          db_cnt_r[i] <= {MUX_LOG2{1'b0}};
        end else if (db_cnt_r[i] == {MUX_LOG2{1'b1}}) begin
          filt_r[i]   <= sync2_r[i];
          db_cnt_r[i] <= {MUX_LOG2{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + MUX_LOG2'(1);
        end
      end
    end
  end

  assign {btn_ss_s, btn_mm_s, btn_hh_s} = filt_r;
`else
  assign btn_hh_s = btn_hh;
  assign btn_mm_s = btn_mm;
  assign btn_ss_s = btn_ss;
`endif

  logic [PW-1:0]         presc_r;
  logic [6:0]            hs_r;
  logic [ONES_W-1:0]     min_o_r, hr_o_r;
  logic [MIN_T_W-1:0]    min_t_r;
  logic [HR_T_W-1:0]     hr_t_r;
  logic [MUX_LOG2-1:0]   scan_cnt_r;
  logic [2:0]            idx_r;
  logic [6:0]            seg_r;
  logic [NDIG-1:0]       dig_en_r;
  logic                  sec_led_r, pm_r;

  logic half_tick_s, min_carry_s, inc_min_s, inc_hr_s, flash_on_s;

  // Timebase events; holding btn_ss suppresses the tick and therefore any carry
  always_comb begin
    half_tick_s = (presc_r == PRESC_MAX) && !btn_ss_s;
    min_carry_s = half_tick_s && (hs_r == 7'd119);
    inc_min_s   = half_tick_s && (btn_mm_s || min_carry_s);
    inc_hr_s    = half_tick_s && (btn_hh_s ||
                  (min_carry_s && min_t_r == 3'd5 && min_o_r == 4'd9));
    flash_on_s  = int'(presc_r) < (1 << FLASH_LOG2);
  end

  // Prescaler and half-second counter; btn_ss pins both at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
      hs_r    <= 7'd0;
    end else if (btn_ss_s) begin
      presc_r <= {PW{1'b0}};
      hs_r    <= 7'd0;
    end else if (half_tick_s) begin
      presc_r <= {PW{1'b0}};
      hs_r    <= (hs_r == 7'd119) ? 7'd0 : hs_r + 7'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // BCD minute/hour fields; button and carry on one tick still step once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_o_r <= 4'd0;
      min_t_r <= 3'd0;
      hr_o_r  <= 4'd0;
      hr_t_r  <= 2'd0;
    end else begin
      if (inc_min_s) begin
        if (min_o_r == 4'd9) begin
          min_o_r <= 4'd0;
          min_t_r <= (min_t_r == 3'd5) ? 3'd0 : min_t_r + 3'd1;
        end else begin
          min_o_r <= min_o_r + 4'd1;
        end
      end
      if (inc_hr_s) begin
        if (hr_t_r == 2'd2 && hr_o_r == 4'd3) begin
          hr_o_r <= 4'd0;
          hr_t_r <= 2'd0;
        end else if (hr_o_r == 4'd9) begin
          hr_o_r <= 4'd0;
          hr_t_r <= hr_t_r + 2'd1;
        end else begin
          hr_o_r <= hr_o_r + 4'd1;
        end
      end
    end
  end

  // Digit scan: dwell 2^MUX_LOG2 cycles per digit, index 0..NDIG-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= {MUX_LOG2{1'b0}};
      idx_r      <= 3'd0;
    end else begin
      scan_cnt_r <= scan_cnt_r + MUX_LOG2'(1);
      if (scan_cnt_r == {MUX_LOG2{1'b1}}) begin
        idx_r <= (idx_r == 3'(NDIG - 1)) ? 3'd0 : idx_r + 3'd1;
      end
    end
  end

  logic [4:0]        hr_bin_s, hr_12_s;
  logic [HR_T_W-1:0] hr_t_disp_s;
  logic [ONES_W-1:0] hr_o_disp_s, digit_s;
  logic [5:0]        sec_bin_s;
  logic [2:0]        pos_s;
  logic              blank_s, pm_s;
  logic [6:0]        dec_seg_s;

  // Displayed hour digits (12h face when enabled) and the pm flag
  always_comb begin
    hr_bin_s = 5'(hr_t_r) * 5'd10 + 5'(hr_o_r);
    hr_12_s  = hour_to_12h(hr_bin_s);
    if (MODE_12H != 0) begin
      hr_t_disp_s = (hr_12_s >= 5'd10) ? 2'd1 : 2'd0;
      hr_o_disp_s = (hr_12_s >= 5'd10) ? 4'(hr_12_s - 5'd10) : 4'(hr_12_s);
    end else begin
      hr_t_disp_s = hr_t_r;
      hr_o_disp_s = hr_o_r;
    end
    pm_s = (MODE_12H != 0) && (hr_bin_s >= 5'd12);
  end

  // Pick the digit under the scan; 4-digit builds skip the two seconds positions
  always_comb begin
    pos_s     = idx_r + ((SHOW_SEC != 0) ? 3'd0 : 3'd2);
    sec_bin_s = hs_r[6:1];
    digit_s   = 4'd0;
    blank_s   = 1'b0;
    case (pos_s)
      3'd0: digit_s = 4'(sec_bin_s % 6'd10);
      3'd1: digit_s = 4'(sec_bin_s / 6'd10);
      3'd2: digit_s = min_o_r;
      3'd3: digit_s = 4'(min_t_r);
      3'd4: digit_s = hr_o_disp_s;
      3'd5: begin
        digit_s = 4'(hr_t_disp_s);
        blank_s = (hr_t_disp_s == 2'd0);
      end
      default: blank_s = 1'b1;
    endcase
  end

  seg7_decode u_dec (
    .digit (digit_s),
    .blank (blank_s),
    .seg   (dec_seg_s)
  );

  // Output registers; safe mode darkens the display and gates the tick LED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r     <= 7'd0;
      dig_en_r  <= {NDIG{1'b0}};
      sec_led_r <= 1'b0;
      pm_r      <= 1'b0;
    end else if (!btn_safe_n) begin
      seg_r     <= 7'd0;
      dig_en_r  <= {NDIG{1'b0}};
      sec_led_r <= hs_r[0] && flash_on_s;
      pm_r      <= pm_s;
    end else begin
      seg_r     <= dec_seg_s;
      dig_en_r  <= NDIG'(1) << idx_r;
      sec_led_r <= hs_r[0];
      pm_r      <= pm_s;
    end
  end

  assign seg     = seg_r;
  assign dig_en  = dig_en_r;
  assign sec_led = sec_led_r;
  assign pm      = pm_r;

endmodule

// File: tb/tb_seg_clock_mux.sv
// Directed bench for seg_clock_mux: a 24h/6-digit and a 12h/4-digit instance
// share one stimulus stream (CLK_HZ=8, MUX_LOG2=1, FLASH_LOG2=1).
module tb_seg_clock_mux;

  logic clk = 1'b0;
  logic rst_n, btn_hh, btn_mm, btn_ss, btn_safe_n;
  logic [6:0] seg_a, seg_b;
  logic [5:0] dig_en_a;
  logic [3:0] dig_en_b;
  logic sec_led_a, sec_led_b, pm_a, pm_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  seg_clock_mux #(.CLK_HZ(8), .SHOW_SEC(1), .MUX_LOG2(1), .MODE_12H(0), .FLASH_LOG2(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_hh(btn_hh), .btn_mm(btn_mm), .btn_ss(btn_ss),
    .btn_safe_n(btn_safe_n), .seg(seg_a), .dig_en(dig_en_a), .sec_led(sec_led_a), .pm(pm_a));

  seg_clock_mux #(.CLK_HZ(8), .SHOW_SEC(0), .MUX_LOG2(1), .MODE_12H(1), .FLASH_LOG2(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_hh(btn_hh), .btn_mm(btn_mm), .btn_ss(btn_ss),
    .btn_safe_n(btn_safe_n), .seg(seg_b), .dig_en(dig_en_b), .sec_led(sec_led_b), .pm(pm_b));

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: glyph = 7'h3F;  1: glyph = 7'h06;  2: glyph = 7'h5B;  3: glyph = 7'h4F;
      4: glyph = 7'h66;  5: glyph = 7'h6D;  6: glyph = 7'h7D;  7: glyph = 7'h07;
      8: glyph = 7'h7F;  9: glyph = 7'h6F;  default: glyph = 7'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cyc", cyc, target);
  endtask

  task automatic chk_dig_a(input string tag, input int idx, input logic [6:0] exp);
    int n = 0;
    while (dig_en_a !== (6'b000001 << idx) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {dig_en_a, seg_a}, {6'b000001 << idx, exp});
  endtask

  task automatic chk_dig_b(input string tag, input int idx, input logic [6:0] exp);
    int n = 0;
    while (dig_en_b !== (4'b0001 << idx) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {dig_en_b, seg_b}, {4'b0001 << idx, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    rst_n = 1'b0; btn_hh = 1'b0; btn_mm = 1'b0; btn_ss = 1'b0; btn_safe_n = 1'b1;
    step(3);
    chk("rst_a", {seg_a, dig_en_a, sec_led_a, pm_a}, 0);
    chk("rst_b", {seg_b, dig_en_b, sec_led_b, pm_b}, 0);

    // Set 23:59 with both buttons: hh for 23 ticks, mm for 59 ticks
    btn_hh = 1'b1; btn_mm = 1'b1; rst_n = 1'b1;
    wait_cyc(92);  btn_hh = 1'b0;
    wait_cyc(236); btn_mm = 1'b0;
    step(1);
    chk_dig_a("a_2359_ht", 5, glyph(2));
    chk_dig_a("a_2359_ho", 4, glyph(3));
    chk_dig_a("a_2359_mt", 3, glyph(5));
    chk_dig_a("a_2359_mo", 2, glyph(9));
    chk_dig_b("b_2359_ht", 3, glyph(1));
    chk_dig_b("b_2359_ho", 2, glyph(1));
    chk("b_2359_pm", pm_b, 1);
    chk("a_pm_const0", pm_a, 0);

    // Natural rollover 23:59 + carry -> 00:00
    wait_cyc(479);
    chk("hs_119", dut_a.hs_r, 119);
    wait_cyc(480);
    chk("hs_wrap", dut_a.hs_r, 0);
    step(1);
    chk_dig_a("a_0000_ht_blank", 5, 7'h00);
    chk_dig_a("a_0000_ho", 4, glyph(0));
    chk_dig_a("a_0000_mt", 3, glyph(0));
    chk_dig_a("a_0000_mo", 2, glyph(0));
    chk_dig_b("b_00_as_12_t", 3, glyph(1));
    chk_dig_b("b_00_as_12_o", 2, glyph(2));
    chk("b_00_pm", pm_b, 0);

    // btn_mm for 61 ticks: minutes 00 -> 01, no hour carry on 59 -> 00
    t = ((cyc / 4) + 1) * 4;
    wait_cyc(t); btn_mm = 1'b1;
    wait_cyc(t + 244); btn_mm = 1'b0;
    step(1);
    chk_dig_a("mm61_mo", 2, glyph(1));
    chk_dig_a("mm61_mt", 3, glyph(0));
    chk_dig_a("mm61_ho", 4, glyph(0));
    chk_dig_a("mm61_ht", 5, 7'h00);

    // Button and natural carry on the same tick: minutes 01 -> 02 only
    wait_cyc(959); btn_mm = 1'b1;
    wait_cyc(960); btn_mm = 1'b0;
    chk("same_tick_hs", dut_a.hs_r, 0);
    step(1);
    chk_dig_a("same_tick_mo", 2, glyph(2));
    chk_dig_a("same_tick_ho", 4, glyph(0));

    // btn_ss pulse at hs=57 clears hs and prescaler; next tick 4 cycles later
    wait_cyc(1189);
    chk("ss_pre_hs", dut_a.hs_r, 57);
    btn_ss = 1'b1;
    wait_cyc(1190); btn_ss = 1'b0;
    chk("ss_hs0", dut_a.hs_r, 0);
    chk("ss_presc0", dut_a.presc_r, 0);
    wait_cyc(1193);
    chk("ss_presc3", dut_a.presc_r, 3);
    chk("ss_hs_still0", dut_a.hs_r, 0);
    wait_cyc(1194);
    chk("ss_tick", dut_a.hs_r, 1);

    // Reset during a button hold; first tick CLK_HZ/2 cycles after release
    btn_hh = 1'b1; rst_n = 1'b0;
    step(2);
    chk("rst2_a", {seg_a, dig_en_a, sec_led_a, pm_a}, 0);
    rst_n = 1'b1;
    wait_cyc(3);
    chk("rel_hs_e3", dut_a.hs_r, 0);
    wait_cyc(4);
    chk("rel_hs_e4", dut_a.hs_r, 1);
    wait_cyc(52); btn_hh = 1'b0;
    step(1);
    chk_dig_a("a_13_ht", 5, glyph(1));
    chk_dig_a("a_13_ho", 4, glyph(3));
    chk_dig_b("b_13_ht_blank", 3, 7'h00);
    chk_dig_b("b_13_ho", 2, glyph(1));
    chk("b_13_pm", pm_b, 1);

    // Normal sec_led follows hs[0]
    for (int i = 0; i < 6; i++) begin
      chk("sec_led_norm", sec_led_a, ((cyc - 1) / 4) % 2);
      step(1);
    end

    // Safe mode: display dark next cycle, LED flashes on early prescaler phases
    btn_safe_n = 1'b0;
    step(1);
    chk("safe_dig_a", dig_en_a, 0);
    chk("safe_seg_a", seg_a, 0);
    chk("safe_dig_b", dig_en_b, 0);
    for (int i = 0; i < 8; i++) begin
      chk("sec_led_safe", sec_led_a,
          ((((cyc - 1) / 4) % 2) == 1 && ((cyc - 1) % 4) < 2) ? 1 : 0);
      step(1);
    end
    chk("safe_hs_runs", dut_a.hs_r, (cyc / 4) % 120);
    btn_safe_n = 1'b1;
    step(2);
    chk("safe_exit", $countones(dig_en_a), 1);

    // Asynchronous reset mid-scan clears outputs before any clock edge
    n = 0;
    while (dig_en_b !== 4'b0100 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("scan_0100", dig_en_b, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", {seg_a, dig_en_a, sec_led_a, pm_a}, 0);
    chk("async_rst_b", {seg_b, dig_en_b, sec_led_b, pm_b}, 0);
    step(2);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_clock_mux.md
SEG_CLOCK_MUX -- requirements
Module: seg_clock_mux

Interface
REQ-001 Parameter CLK_HZ, default 32768, input clock frequency in Hz; even, >=4.
REQ-002 Parameter SHOW_SEC, default 0, 0 = 4 digits HH:MM, 1 = 6 digits HH:MM:SS; NDIG = 4 + 2*SHOW_SEC.
REQ-003 Parameter MUX_LOG2, default 7, digit dwell of 2^MUX_LOG2 clk cycles.
REQ-004 Parameter MODE_12H, default 0, 0 = display hours 00..23, 1 = display hours 1..12.
REQ-005 Parameter FLASH_LOG2, default 6, safe-mode tick flash of 2^FLASH_LOG2 clk cycles.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 btn_hh, btn_mm, btn_ss  input  1 each  active-high set buttons, synchronous to clk.
REQ-009 btn_safe_n  input  1  active-low; low = safe (display off) mode.
REQ-010 seg  output  7  {g,f,e,d,c,b,a}, active-high, registered.
REQ-011 dig_en  output  NDIG  one-hot digit enable, bit 0 = rightmost digit, registered.
REQ-012 sec_led  output  1  half-second tick indicator, registered.
REQ-013 pm  output  1  high for hours 12..23 when MODE_12H=1, else constant 0.

Function
REQ-014 Prescaler counts 0..CLK_HZ/2-1 and wraps; one-cycle half_tick at wrap (2 Hz).
REQ-015 Half-second counter hs counts 0..119 on half_tick; wrap from 119 to 0 is the minute carry.
REQ-016 Time fields are BCD: m 0..9, mm 0..5, h 0..9, hh 0..2; hours range 00..23; 23:59 + carry -> 00:00.
REQ-017 Seconds shown (SHOW_SEC=1) = hs/2 as two BCD digits 00..59.
REQ-018 btn_mm held: minutes +1 on every half_tick, 59 -> 00, no hour carry.
REQ-019 btn_hh held: hours +1 on every half_tick, 23 -> 00.
REQ-020 Button and natural carry on same half_tick into one field: field increments exactly once.
REQ-021 btn_ss high: hs and prescaler held at 0, no minute carry generated while high.
REQ-022 btn_hh and btn_mm both held: both fields increment on the same half_tick, independently.
REQ-023 MODE_12H=1: displayed hour = internal 0 -> 12, 13..23 -> 1..11; internal counting stays 0..23.
REQ-024 Hour tens digit blanked (seg=0 while selected) when its value is 0.
REQ-025 Scan counter advances digit index every 2^MUX_LOG2 cycles, 0..NDIG-1, wrap to 0.
REQ-026 seg/dig_en registered: one-cycle latency from scan index change.
REQ-027 Safe mode: dig_en=0 and seg=0 from the next cycle; timekeeping continues.
REQ-028 sec_led = hs[0] in normal mode; in safe mode hs[0] AND prescaler < 2^FLASH_LOG2.

Reset
REQ-029 rst_n low: prescaler, hs, scan index = 0; time 00:00:00; seg=0, dig_en=0, sec_led=0, pm=0.
REQ-030 Reset mid-count or mid-button-hold aborts immediately; first half_tick after release is CLK_HZ/2 cycles later.

Configuration
REQ-031 Macro SEG_CLOCK_DEBOUNCE_EN defined: each button passes a 2-flop synchroniser plus a debounce filter requiring 2^MUX_LOG2 stable cycles before the filtered level changes.
REQ-032 Macro undefined: buttons are used directly, with no added latency.

Structure
REQ-033 Package seg_clock_pkg holds the 7-segment glyph constants for 0..9 and blank, and the BCD field width constants.
REQ-034 Sub-module seg7_decode (4-bit BCD plus blank -> 7-bit seg) is instantiated once on the muxed digit.

Verification (CLK_HZ=8, MUX_LOG2=1)
REQ-035 Reset release, time preset to 23:59, hs=119, next half_tick -> 00:00, hs=0, pm=0.
REQ-036 btn_mm held for 61 half_ticks from 00:00 -> 01:00? No: minutes -> 01, hours stay 00.
REQ-037 btn_ss pulsed at hs=57 -> hs=0 and prescaler=0; the next half_tick arrives 4 cycles later.
REQ-038 MODE_12H=1, hours=00 -> digits "12", pm=0; hours=13 -> digits " 1", pm=1, tens blank.
REQ-039 btn_safe_n low -> dig_en=0 next cycle; sec_led high only for prescaler<2^FLASH_LOG2 when hs odd.
REQ-040 rst_n asserted mid-scan with dig_en=4'b0100 -> all outputs 0 without waiting for a clk edge.
